mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter: XLEN, 64, datapath width; only 64 is supported.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 valid_i  input  1  decode/execute presents a MUL/DIV/REM operation.
REQ-005 ready_o  output  1  sequencer can accept an operation this cycle.
REQ-006 op_i  input  2  operation select: 00 MUL, 01 DIV, 10 REM, 11 reserved (treated as MUL).
REQ-007 sign_i  input  1  signed operation (the decoder's alu_sign).
REQ-008 cut_i  input  1  32-bit word variant (the decoder's alu_cut).
REQ-009 a_i  input  XLEN  rs1 operand.
REQ-010 b_i  input  XLEN  rs2 operand.
REQ-011 flush_i  input  1  kill any in-flight or offered operation.
REQ-012 busy_o  output  1  operation in flight; the pipeline uses it as a stall.
REQ-013 done_o  output  1  one-cycle pulse marking result_o valid.
REQ-014 result_o  output  XLEN  final result; held stable until the next acceptance.

Function
REQ-015 FSM states are IDLE, BUSY and DONE; ready_o = (state==IDLE); busy_o = (state!=IDLE).
REQ-016 Acceptance occurs when valid_i && ready_o && !flush_i, and latches op, sign, cut and the operands.
REQ-017 Iteration count N = 32 when cut_i = 1, else 64.
REQ-018 Normal path: accept in cycle 0; BUSY in cycles 1..N with one iteration per cycle; DONE in cycle N+1 with done_o = 1; IDLE in cycle N+2.
REQ-019 MUL uses shift-add and returns the low XLEN bits of a*b; sign_i does not affect the result.
REQ-020 DIV/REM use restoring division on magnitudes when sign_i = 1.
REQ-021 Signed quotient sign = sign(a) XOR sign(b); signed remainder takes the sign of the dividend.
REQ-022 Word ops use operands a[31:0] and b[31:0], sign-extended if sign_i = 1 and zero-extended otherwise; the result is its low 32 bits sign-extended to 64.
REQ-023 Division by zero, detected at acceptance, skips BUSY and goes to DONE in cycle 1.
REQ-024 Division by zero returns: DIV quotient all ones (32-bit all ones, sign-extended, for word ops); REM returns the dividend (word-extended per REQ-022).
REQ-025 Signed overflow (most-negative / -1, at the operating width) skips BUSY and goes to DONE in cycle 1.
REQ-026 Signed overflow returns: DIV returns the dividend; REM returns 0.
REQ-027 The DONE->IDLE transition is unconditional; a new operation can be accepted no earlier than cycle N+2.
REQ-028 flush_i = 1 in any state forces IDLE at the next edge and suppresses done_o for the killed operation; result_o keeps its previous value.
REQ-029 flush_i and valid_i high in the same cycle: the operation is not accepted.
REQ-030 valid_i while busy is ignored; the requester holds it until ready_o = 1.

Reset
REQ-031 With resetn = 0: state = IDLE, ready_o = 1, busy_o = 0, done_o = 0, result_o = 0, iteration counter = 0.
REQ-032 Assertion of resetn mid-operation aborts the operation immediately and asynchronously; no done_o follows.
REQ-033 The first acceptance is possible in the first cycle after resetn deasserts.

Verification
REQ-034 MUL, sign=0, cut=0, a=3, b=0xFFFFFFFFFFFFFFFE -> done_o in cycle 65, result 0xFFFFFFFFFFFFFFFA; busy_o high in cycles 1..65.
REQ-035 DIV then REM, sign=1, a=-7, b=2 -> quotient 0xFFFFFFFFFFFFFFFD at cycle 65; remainder 0xFFFFFFFFFFFFFFFF at cycle 65 of the second operation.
REQ-036 DIV, sign=0, b=0, a=5 -> done_o in cycle 1, result all ones; REM with the same operands -> result 5.
REQ-037 DIV, sign=1, a=0x8000000000000000, b=-1 -> result 0x8000000000000000 in cycle 1; REM -> 0.
REQ-038 DIV, cut=1, sign=1, a=0x00000000FFFFFFF8, b=3 -> result 0xFFFFFFFFFFFFFFFE, done_o in cycle 33.
REQ-039 Flush at cycle 10 of a 64-bit DIV -> IDLE at cycle 11, no done_o, result_o unchanged.
REQ-040 Repeat the REQ-039 abort using resetn instead of flush_i -> state returns to IDLE immediately, no done_o, result_o = 0.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Handshake and operand bundle between the decode/execute stage and the
// sequential multiply/divide unit. The master side offers an operation,
// the slave side (mdu_seq) reports readiness, stall and the result.
`timescale 1ns/1ps

interface mdu_seq_if #(
   parameter int XLEN = 64
);
   logic            valid_i;
   logic            ready_o;
   logic [1:0]      op_i;
   logic            sign_i;
   logic            cut_i;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic            flush_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output valid_i, op_i, sign_i, cut_i, a_i, b_i, flush_i,
      input  ready_o, busy_o, done_o, result_o
   );

   modport slave (
      input  valid_i, op_i, sign_i, cut_i, a_i, b_i, flush_i,
      output ready_o, busy_o, done_o, result_o
   );
endinterface

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit. One iteration per cycle: shift-add for
// MUL, restoring division on magnitudes for DIV/REM. Word variants run 32
// iterations on the low operand halves and sign-extend the 32-bit result.
// Division by zero and signed overflow are resolved at acceptance and go
// straight to DONE without iterating.
`timescale 1ns/1ps

module mdu_seq #(
   parameter int XLEN = 64
) (
   input  logic     clk,
   input  logic     resetn,
   mdu_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0]      OP_DIV   = 2'b01;
   localparam logic [1:0]      OP_REM   = 2'b10;
   localparam logic [XLEN-1:0] MIN_D    = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W    = {{(XLEN-31){1'b1}}, 31'b0};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   state_e          state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] opa_q, opa_d;
   logic [XLEN-1:0] opb_q, opb_d;
   logic [1:0]      op_q, op_d;
   logic            cut_q, cut_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            in_is_div, in_is_rem;
   logic [XLEN-1:0] a_ext, b_ext, a_word, a_mag, b_mag;
   logic            a_neg, b_neg, b_zero, ovf;

   logic            q_is_div, q_is_rem;
   logic [XLEN:0]   rem_sh;
   logic            rem_ge;
   logic [XLEN-1:0] rem_diff;
   logic [XLEN-1:0] acc_step, opa_step, opb_step;
   logic [XLEN-1:0] res_raw, res_final;
   logic [5:0]      last_cnt;

   // Decode the offered operation: extended operands, magnitudes and the
   // two early-exit cases that never need the iterative datapath.
   always_comb begin
      in_is_rem = (bus.op_i == OP_REM);
      in_is_div = (bus.op_i == OP_DIV) || in_is_rem;
      a_word    = bus.cut_i ? {{(XLEN-32){bus.a_i[31]}}, bus.a_i[31:0]} : bus.a_i;
      if (bus.cut_i) begin
         a_ext = bus.sign_i ? {{(XLEN-32){bus.a_i[31]}}, bus.a_i[31:0]}
                            : {{(XLEN-32){1'b0}}, bus.a_i[31:0]};
         b_ext = bus.sign_i ? {{(XLEN-32){bus.b_i[31]}}, bus.b_i[31:0]}
                            : {{(XLEN-32){1'b0}}, bus.b_i[31:0]};
      end else begin
         a_ext = bus.a_i;
         b_ext = bus.b_i;
      end
      a_neg  = bus.sign_i && a_ext[XLEN-1];
      b_neg  = bus.sign_i && b_ext[XLEN-1];
      a_mag  = a_neg ? (~a_ext + 1'b1) : a_ext;
      b_mag  = b_neg ? (~b_ext + 1'b1) : b_ext;
      b_zero = (b_ext == '0);
      ovf    = bus.sign_i && (b_ext == ALL_ONES) &&
               (a_ext == (bus.cut_i ? MIN_W : MIN_D));
   end

   // One iteration of the latched operation, plus the signed/word fix-up
   // applied to that iteration's outcome when it is the final one.
   always_comb begin
      q_is_rem = (op_q == OP_REM);
      q_is_div = (op_q == OP_DIV) || q_is_rem;
      rem_sh   = {acc_q, opa_q[XLEN-1]};
      rem_ge   = (rem_sh >= {1'b0, opb_q});
      rem_diff = rem_sh[XLEN-1:0] - opb_q;
      if (q_is_div) begin
         acc_step = rem_ge ? rem_diff : rem_sh[XLEN-1:0];
         opa_step = {opa_q[XLEN-2:0], rem_ge};
         opb_step = opb_q;
      end else begin
         acc_step = opb_q[0] ? (acc_q + opa_q) : acc_q;
         opa_step = opa_q << 1;
         opb_step = opb_q >> 1;
      end
      if (q_is_rem) begin
         res_raw = negr_q ? (~acc_step + 1'b1) : acc_step;
      end else if (q_is_div) begin
         res_raw = negq_q ? (~opa_step + 1'b1) : opa_step;
      end else begin
         res_raw = acc_step;
      end
      res_final = cut_q ? {{(XLEN-32){res_raw[31]}}, res_raw[31:0]} : res_raw;
      last_cnt  = cut_q ? 6'd31 : 6'd63;
   end

   // Next-state logic: accept from IDLE, iterate in BUSY, single-cycle DONE.
   // A flush kills whatever is in flight without touching the result.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      op_d     = op_q;
      cut_d    = cut_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (bus.valid_i && !bus.flush_i) begin
               op_d   = bus.op_i;
               cut_d  = bus.cut_i;
               negq_d = a_neg ^ b_neg;
               negr_d = a_neg;
               cnt_d  = '0;
               acc_d  = '0;
               if (in_is_div && b_zero) begin
                  result_d = in_is_rem ? a_word : ALL_ONES;
                  state_d  = DONE;
               end else if (in_is_div && ovf) begin
                  result_d = in_is_rem ? '0 : a_word;
                  state_d  = DONE;
               end else if (in_is_div) begin
                  opa_d   = bus.cut_i ? {a_mag[31:0], 32'b0} : a_mag;
                  opb_d   = b_mag;
                  state_d = BUSY;
               end else begin
                  opa_d   = bus.a_i;
                  opb_d   = bus.b_i;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (bus.flush_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = acc_step;
               opa_d = opa_step;
               opb_d = opb_step;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == last_cnt) begin
                  result_d = res_final;
                  cnt_d    = '0;
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation at once.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         op_q     <= '0;
         cut_q    <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         op_q     <= op_d;
         cut_q    <= cut_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
      end
   end

   assign bus.ready_o  = (state_q == IDLE);
   assign bus.busy_o   = (state_q != IDLE);
   assign bus.done_o   = (state_q == DONE);
   assign bus.result_o = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: normal MUL/DIV/REM timing and results,
// early exits, word variants, flush, busy-hold and asynchronous reset abort.
`timescale 1ns/1ps

module tb_mdu_seq;

   logic clk = 1'b0;
   logic resetn;
   int   tests  = 0;
   int   failed = 0;

   mdu_seq_if #(.XLEN(64)) bus ();

   mdu_seq #(.XLEN(64)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic s,
                                input logic c, input logic [63:0] a,
                                input logic [63:0] b, input logic f);
      bus.valid_i = v;
      bus.op_i    = op;
      bus.sign_i  = s;
      bus.cut_i   = c;
      bus.a_i     = a;
      bus.b_i     = b;
      bus.flush_i = f;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 of cycle startCyc; returns the cycle where done_o is seen
   task automatic waitDone(input int startCyc, output int doneCyc, output logic busyOk);
      int cyc;
      cyc    = startCyc;
      busyOk = 1'b1;
      while (bus.done_o !== 1'b1 && cyc <= 200) begin
         if (bus.busy_o !== 1'b1) busyOk = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (bus.busy_o !== 1'b1) busyOk = 1'b0;
      doneCyc = cyc;
   endtask

   task automatic runOp(input string tag, input logic [1:0] op, input logic s,
                        input logic c, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] expRes, input int expCyc);
      int   dc;
      logic bo;
      @(negedge clk);
      applyStimulus(1'b1, op, s, c, a, b, 1'b0);
      checkOutput({tag, ".ready"}, 64'(bus.ready_o), 64'd1);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, op, s, c, a, b, 1'b0);
      waitDone(1, dc, bo);
      checkOutput({tag, ".cycle"}, 64'(dc), 64'(expCyc));
      checkOutput({tag, ".result"}, bus.result_o, expRes);
      checkOutput({tag, ".busy"}, 64'(bo), 64'd1);
      @(posedge clk);
      #1;
      checkOutput({tag, ".idle"}, {62'b0, bus.ready_o, bus.done_o}, 64'd2);
   endtask

   initial begin : main
      int   dones;
      int   dc;
      logic bo;

      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      resetn = 1'b0;
      #12;
      checkOutput("rst.ready",  64'(bus.ready_o), 64'd1);
      checkOutput("rst.busy",   64'(bus.busy_o),  64'd0);
      checkOutput("rst.done",   64'(bus.done_o),  64'd0);
      checkOutput("rst.result", bus.result_o,     64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      runOp("mul64",   2'b00, 1'b0, 1'b0, 64'd3, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFA, 65);
      runOp("div_s",   2'b01, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65);
      runOp("rem_s",   2'b10, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65);
      runOp("div0",    2'b01, 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
      runOp("rem0",    2'b10, 1'b0, 1'b0, 64'd5, 64'd0, 64'd5, 1);
      runOp("div_ovf", 2'b01, 1'b1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
            64'h8000000000000000, 1);
      runOp("rem_ovf", 2'b10, 1'b1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
            64'd0, 1);
      runOp("divw",    2'b01, 1'b1, 1'b1, 64'h00000000FFFFFFF8, 64'd3, 64'hFFFFFFFFFFFFFFFE, 33);
      runOp("mulw",    2'b00, 1'b0, 1'b1, 64'hDEAD000040000000, 64'h1234000000000002,
            64'hFFFFFFFF80000000, 33);
      runOp("divu",    2'b01, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd16, 64'h0FFFFFFFFFFFFFFF, 65);
      runOp("remu",    2'b10, 1'b0, 1'b0, 64'd100, 64'd7, 64'd2, 65);
      runOp("remw0",   2'b10, 1'b0, 1'b1, 64'h1234567887654321, 64'hABCD000000000000,
            64'hFFFFFFFF87654321, 1);
      runOp("mul_rsv", 2'b11, 1'b1, 1'b0, 64'd5, 64'd6, 64'd30, 65);

      // Flush at cycle 10 of a 64-bit divide
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 64'd1000, 64'd3, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 64'd1000, 64'd3, 1'b0);
      dones = 0;
      repeat (9) begin
         @(posedge clk);
         #1;
         if (bus.done_o === 1'b1) dones++;
      end
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 64'd1000, 64'd3, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 64'd1000, 64'd3, 1'b0);
      checkOutput("flush.ready", 64'(bus.ready_o), 64'd1);
      checkOutput("flush.busy",  64'(bus.busy_o),  64'd0);
      repeat (80) begin
         if (bus.done_o === 1'b1) dones++;
         @(posedge clk);
         #1;
      end
      checkOutput("flush.done",   64'(dones),   64'd0);
      checkOutput("flush.result", bus.result_o, 64'd30);

      // Valid together with flush is not accepted
      @(negedge clk);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 64'd5, 64'd6, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 64'd5, 64'd6, 1'b0);
      checkOutput("flushv.busy",  64'(bus.busy_o),  64'd0);
      checkOutput("flushv.ready", 64'(bus.ready_o), 64'd1);

      // A new offer while busy must be ignored
      @(negedge clk);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 64'd7, 64'd9, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 64'd100, 64'd0, 1'b0);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 64'd100, 64'd0, 1'b0);
      waitDone(6, dc, bo);
      checkOutput("hold.cycle",  64'(dc),       64'd33);
      checkOutput("hold.result", bus.result_o, 64'd63);
      checkOutput("hold.busy",   64'(bo),       64'd1);
      @(posedge clk);
      #1;
      checkOutput("hold.idle", 64'(bus.ready_o), 64'd1);

      // Asynchronous reset at cycle 10 of a 64-bit divide
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 64'd1000, 64'd3, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 64'd1000, 64'd3, 1'b0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("arst.ready",  64'(bus.ready_o), 64'd1);
      checkOutput("arst.busy",   64'(bus.busy_o),  64'd0);
      checkOutput("arst.result", bus.result_o,     64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      dones  = 0;
      repeat (80) begin
         if (bus.done_o === 1'b1) dones++;
         @(posedge clk);
         #1;
      end
      checkOutput("arst.done",   64'(dones),   64'd0);
      checkOutput("arst.hold",   bus.result_o, 64'd0);

      // Acceptance right after reset release
      @(posedge clk);
      #1;
      resetn = 1'b0;
      #2;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      runOp("mul_post", 2'b00, 1'b0, 1'b0, 64'h0000000100000001, 64'h0000000100000001,
            64'h0000000200000001, 65);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
